// File: rtl/control_pkg.sv
// Shared types and constants for the phase-2 CPU control sequencer:
// sequencer states, opcode values, ALU operation codes and instruction classes.
package control_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_F0   = 4'd1,
        S_F1   = 4'd2,
        S_F2   = 4'd3,
        S_E0   = 4'd4,
        S_EXS  = 4'd5,
        S_EXW  = 4'd6,
        S_WB   = 4'd7,
        S_M0   = 4'd8,
        S_M1   = 4'd9,
        S_M2   = 4'd10,
        S_HALT = 4'd11
    } state_e;

    typedef enum logic [2:0] {
        OP_ALU_REG = 3'd0,
        OP_ALU_IMM = 3'd1,
        OP_LDI     = 3'd2,
        OP_LD      = 3'd3,
        OP_ST      = 3'd4,
        OP_NOP     = 3'd5,
        OP_HALT    = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_class_e;

    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_LDI  = 5'b00001;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_ADDI = 5'b01100;
    localparam logic [4:0] OPC_ANDI = 5'b01101;
    localparam logic [4:0] OPC_ORI  = 5'b01110;
    localparam logic [4:0] OPC_NOP  = 5'b11010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    localparam logic [5:0] ALU_ADD = 6'd0;
    localparam logic [5:0] ALU_SUB = 6'd1;
    localparam logic [5:0] ALU_AND = 6'd2;
    localparam logic [5:0] ALU_OR  = 6'd3;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: maps the 5-bit opcode to an instruction
// class and the ALU operation it needs. Unknown opcodes decode as ILLEGAL.
module instr_decode
    import control_pkg::*;
(
    input  logic [4:0] opcode_i,
    output op_class_e  op_class_o,
    output logic [5:0] alu_op_o
);

    // Classify the opcode and pick its ALU operation (memory forms use ADD for address arithmetic)
    always_comb begin
        op_class_o = OP_ILLEGAL;
        alu_op_o   = ALU_ADD;
        case (opcode_i)
            OPC_LD:   begin op_class_o = OP_LD;      alu_op_o = ALU_ADD; end
            OPC_LDI:  begin op_class_o = OP_LDI;     alu_op_o = ALU_ADD; end
            OPC_ST:   begin op_class_o = OP_ST;      alu_op_o = ALU_ADD; end
            OPC_ADD:  begin op_class_o = OP_ALU_REG; alu_op_o = ALU_ADD; end
            OPC_SUB:  begin op_class_o = OP_ALU_REG; alu_op_o = ALU_SUB; end
            OPC_AND:  begin op_class_o = OP_ALU_REG; alu_op_o = ALU_AND; end
            OPC_OR:   begin op_class_o = OP_ALU_REG; alu_op_o = ALU_OR;  end
            OPC_ADDI: begin op_class_o = OP_ALU_IMM; alu_op_o = ALU_ADD; end
            OPC_ANDI: begin op_class_o = OP_ALU_IMM; alu_op_o = ALU_AND; end
            OPC_ORI:  begin op_class_o = OP_ALU_IMM; alu_op_o = ALU_OR;  end
            OPC_NOP:  begin op_class_o = OP_NOP;     alu_op_o = ALU_ADD; end
            OPC_HALT: begin op_class_o = OP_HALT;    alu_op_o = ALU_ADD; end
            default:  begin op_class_o = OP_ILLEGAL; alu_op_o = ALU_ADD; end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer for the phase-2 CPU. Runs fetch, then a
// per-class execute sequence, handshaking with the ALU and memory. Outputs
// are Moore-decoded from the state register (plus the IR opcode), so an
// asynchronous clear forces every output low without waiting for a clock.
module control_unit
    import control_pkg::*;
#(
    parameter int unsigned IR_W = 32
) (
    input  logic            Clock,
    input  logic            clear,
    input  logic            run,
    input  logic [IR_W-1:0] IR,
    input  logic            finished,
    input  logic            memFinished,
    output logic            PCout,
    output logic            RZLOout,
    output logic            MDRout,
    output logic            Immout,
    output logic            BAout,
    output logic            Rout,
    output logic            PCin,
    output logic            IRin,
    output logic            RYin,
    output logic            RZin,
    output logic            MARin,
    output logic            MDRin,
    output logic            Rin,
    output logic            IncPC,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Read,
    output logic            Write,
    output logic [5:0]      opSelect,
    output logic            start,
    output logic            halted,
    output logic            illegal,
    output logic            retired
);

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    op_class_e  op_class_s;
    logic [5:0] alu_op_s;
    logic       unused_ir_s;

    // Only the opcode field steers the sequencer; operand fields belong to the datapath.
    assign unused_ir_s = ^IR[IR_W-6:0];

    instr_decode u_decode (
        .opcode_i   (IR[IR_W-1 -: 5]),
        .op_class_o (op_class_s),
        .alu_op_o   (alu_op_s)
    );

    // State register and sticky illegal flag, both cleared asynchronously
    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic: run is only consulted in IDLE and at the end of an instruction
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: state_d = run ? S_F0 : S_IDLE;
            S_F0:   state_d = S_F1;
            S_F1:   state_d = memFinished ? S_F2 : S_F1;
            S_F2:   state_d = S_E0;
            S_E0: begin
                case (op_class_s)
                    OP_NOP:     state_d = S_F0;
                    OP_HALT:    state_d = S_HALT;
                    OP_ILLEGAL: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                    default:    state_d = S_EXS;
                endcase
            end
            S_EXS:  state_d = S_EXW;
            S_EXW: begin
                if (!finished) begin
                    state_d = S_EXW;
                end else if (op_class_s == OP_LD || op_class_s == OP_ST) begin
                    state_d = S_M0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB:   state_d = run ? S_F0 : S_IDLE;
            S_M0:   state_d = S_M1;
            S_M1: begin
                if (op_class_s == OP_ST || memFinished) begin
                    state_d = S_M2;
                end else begin
                    state_d = S_M1;
                end
            end
            S_M2: begin
                if (op_class_s == OP_ST && !memFinished) begin
                    state_d = S_M2;
                end else begin
                    state_d = run ? S_F0 : S_IDLE;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode: everything defaults low and each state raises only its own controls
    always_comb begin
        PCout    = 1'b0;
        RZLOout  = 1'b0;
        MDRout   = 1'b0;
        Immout   = 1'b0;
        BAout    = 1'b0;
        Rout     = 1'b0;
        PCin     = 1'b0;
        IRin     = 1'b0;
        RYin     = 1'b0;
        RZin     = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        Rin      = 1'b0;
        IncPC    = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Read     = 1'b0;
        Write    = 1'b0;
        opSelect = 6'd0;
        start    = 1'b0;
        halted   = 1'b0;
        retired  = 1'b0;
        case (state_q)
            S_IDLE: halted = 1'b0;
            S_F0:   IncPC = 1'b1;
            S_F1: begin
                PCout = 1'b1;
                MARin = 1'b1;
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            S_F2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_E0: begin
                if (op_class_s == OP_NOP || op_class_s == OP_HALT) begin
                    retired = 1'b1;
                end else if (op_class_s == OP_ILLEGAL) begin
                    retired = 1'b0;
                end else begin
                    Grb   = 1'b1;
                    Rout  = 1'b1;
                    RYin  = 1'b1;
                    BAout = (op_class_s != OP_ALU_REG);
                end
            end
            S_EXS, S_EXW: begin
                start    = (state_q == S_EXS);
                RZin     = 1'b1;
                opSelect = alu_op_s;
                if (op_class_s == OP_ALU_REG) begin
                    Grc  = 1'b1;
                    Rout = 1'b1;
                end else begin
                    Immout = 1'b1;
                end
            end
            S_WB: begin
                RZLOout = 1'b1;
                Gra     = 1'b1;
                Rin     = 1'b1;
                retired = 1'b1;
            end
            S_M0: begin
                RZLOout = 1'b1;
                MARin   = 1'b1;
            end
            S_M1: begin
                MDRin = 1'b1;
                if (op_class_s == OP_ST) begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                end else begin
                    Read = 1'b1;
                end
            end
            S_M2: begin
                if (op_class_s == OP_ST) begin
                    Write   = 1'b1;
                    retired = memFinished;
                end else begin
                    MDRout  = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                    retired = 1'b1;
                end
            end
            S_HALT: halted = 1'b1;
            default: halted = 1'b0;
        endcase
    end

    assign illegal = illegal_q;

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the phase-2 CPU; sits directly upstream of `DataPath` and drives every bus-select, register-enable, ALU and memory control line that benches currently toggle by hand. It runs fetch (T0–T2), then a per-opcode execute sequence read from the datapath's IR. It handshakes with the ALU (`start`/`finished`) and with memory (`Read`/`Write`/`memFinished`).

## Interface
- `IR_W`, default 32: instruction width.
- `Clock`  in  1: system clock, rising edge.
- `clear`  in  1: asynchronous, active-high reset.
- `run`  in  1: level. Leave IDLE and keep fetching while high.
- `IR`  in  32: datapath IR contents. Valid from E0 until the next `IRin`.
- `finished`  in  1: ALU done, level.
- `memFinished`  in  1: memory access done, level.
- `PCout, RZLOout, MDRout, Immout, BAout, Rout`  out  1 each: bus drivers.
- `PCin, IRin, RYin, RZin, MARin, MDRin, Rin, IncPC`  out  1 each: write enables.
- `Gra, Grb, Grc`  out  1 each: register-field selects.
- `Read, Write`  out  1 each: memory strobes.
- `opSelect`  out  6: ALU operation.
- `start`  out  1: one-cycle ALU start pulse.
- `halted`  out  1: high in HALT.
- `illegal`  out  1: sticky flag, cleared only by `clear`.
- `retired`  out  1: one-cycle pulse on the last cycle of each instruction.

## Operation
- Opcode field is IR[31:27]. Supported opcodes:
  - ld 00000, ldi 00001, st 00010
  - add 00011, sub 00100, and 00101, or 00110
  - addi 01100, andi 01101, ori 01110
  - nop 11010, halt 11011
  - Every other opcode goes to HALT and sets `illegal`.
- ALU codes: ADD=0, SUB=1, AND=2, OR=3. Immediate forms use the same code as their register form; ld, ldi and st use ADD.
- States: IDLE, F0, F1, F2, E0, EXS, EXW, WB, M0, M1, M2, HALT.
- Outputs are Moore-decoded from the state register plus IR-derived opcode. Every output is 0 in any state that does not list it below.
- Fetch:
  - IDLE: all outputs 0. Go to F0 when `run`=1.
  - F0: `IncPC`.
  - F1: `PCout MARin Read MDRin`. Hold while `memFinished`=0.
  - F2: `MDRout IRin`.
- E0:
  - reg ALU ops: `Grb Rout RYin`.
  - ldi, ld, st, immediate ops: `Grb Rout BAout RYin`.
  - nop: no outputs; go to F0 with `retired`.
  - halt: go to HALT with `retired`.
- EXS: one cycle of `start RZin` plus operand drive and `opSelect`.
  - reg forms drive `Grc Rout`.
  - all others drive `Immout`.
- EXW: same as EXS but `start`=0. Hold while `finished`=0.
  - On exit, go to WB for ALU ops and ldi, or to M0 for ld and st.
- WB: `RZLOout Gra Rin` and `retired`. Go to F0, or to IDLE if `run`=0.
- Load path (M0 → M1 → M2, then F0/IDLE like WB):
  - M0: `RZLOout MARin`.
  - M1: `Read MDRin`. Hold while `memFinished`=0.
  - M2: `MDRout Gra Rin` and `retired`.
- Store path (M0 → M1 → M2, then F0/IDLE like WB):
  - M0: `RZLOout MARin`.
  - M1: `Gra Rout MDRin` (MDR loads from the bus because `Read`=0).
  - M2: `Write`. Hold while `memFinished`=0; assert `retired` on the exit cycle.
- HALT is terminal: `halted`=1 until `clear`.
- `run` is sampled only in IDLE, WB and M2. Deasserting it mid-instruction never aborts the instruction.

## Timing
- `clear` drives the state to IDLE asynchronously. All outputs go to 0 in the same delta, including during F1, M1 or M2 waits, so `Read` and `Write` drop immediately. `illegal` also goes to 0.
- Instruction latency with zero-wait `memFinished` and `finished` (each high in its first wait cycle):
  - ALU ops, ldi: 7 cycles (F0 F1 F2 E0 EXS EXW WB).
  - ld, st: 9 cycles.
  - nop: 4 cycles.
- Each wait-state cycle adds exactly one cycle.
- `start` is high for exactly one cycle per ALU op, even if `finished` is already high in EXS.
- `finished` seen during EXS is ignored. Only EXW samples it.
- `opSelect` and the operand-drive signals are stable through EXS and EXW.

## Structure
- `control_pkg` holds:
  - the state enum;
  - opcode localparams;
  - ALU op codes;
  - the op-class enum (ALU_REG, ALU_IMM, LDI, LD, ST, NOP, HALT, ILLEGAL).
- One combinational sub-module, `instr_decode`: opcode → op class and `opSelect`.
- `control_unit` holds the state register, next-state logic, output decode and the `illegal` flop.

## Test plan
- ori r3,r4,0x55 (IR=0x71A00055), R4=0x2AA, single-cycle handshakes:
  - EXS/EXW show `opSelect`=3 with `Immout`=1.
  - WB shows `Gra Rin RZLOout`; `retired` fires 7 cycles after F0.
- add r1,r2,r3 with `finished` delayed 3 cycles: EXW lasts 3 cycles, `start` is high in EXS only, `Grc Rout` are held throughout.
- ld r1,0x40(r2) with `memFinished` delayed 2 cycles in both F1 and M1: `Read` stays high for 2 cycles in each, total 11 cycles.
- st 0x10(r0),r5: `BAout`=1 in E0, `Gra Rout MDRin` in M1, `Write` held until `memFinished`.
- `clear` asserted mid-EXW: all outputs go to 0 without waiting for a clock edge. After release with `run`=1, fetch restarts at F0.
- Opcode 10010: go to HALT with `illegal`=1 and `halted`=1, with no `Rin` pulse. The block stays there across 10 cycles; halt opcode behaves the same but leaves `illegal`=0.
